reset_sequencer: RTL and testbench

- Consumes the PLL `locked` indication from the clock manager.
- Produces ordered, glitch-free per-domain reset releases for the ADC, DDC, FFT and Ethernet domains, plus a system-ready flag.
- Detects lock loss and lock timeout; on timeout it requests a PLL reset.
- Runs entirely on the 100 MHz reference clock. Each destination domain re-synchronises its reset locally.

---
 rtl/reset_sequencer.sv | 153 +++++++++++++++
 tb/tb_reset_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered per-domain reset release driven by a synchronised PLL lock
// Single 100 MHz clock; every decision uses the synchronised lock, all outputs registered.
module reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 64,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int HOLD_CYCLES        = 256,
  parameter int CNT_W              = 8
) (
  input  logic             clk_100m_in,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             soft_rst,
  output logic             pll_rst,
  output logic             rst_adc,
  output logic             rst_ddc,
  output logic             rst_fft,
  output logic             rst_eth,
  output logic             sys_ready,
  output logic [CNT_W-1:0] lock_loss_cnt
);
  localparam int REL_SPAN = 3 * STAGE_GAP;
  localparam int TMO_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int STAB_W   = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int REL_W    = $clog2(REL_SPAN);
  localparam int PLL_W    = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
  localparam int HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(LOCK_STABLE_CYCLES);
  localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(REL_SPAN - 1);
  localparam logic [REL_W-1:0]  REL_DDC   = REL_W'(STAGE_GAP);
  localparam logic [REL_W-1:0]  REL_FFT   = REL_W'(2 * STAGE_GAP);
  localparam logic [PLL_W-1:0]  PLL_LAST  = PLL_W'(PLL_RST_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK, S_PLL_RESET, S_STABILIZE, S_RELEASE, S_RUN, S_LOST
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [TMO_W-1:0]       r_tmo_cnt, w_tmo_nxt;
  logic [STAB_W-1:0]      r_stab_cnt, w_stab_nxt;
  logic [REL_W-1:0]       r_rel_cnt, w_rel_nxt;
  logic [PLL_W-1:0]       r_pll_cnt, w_pll_nxt;
  logic [HOLD_W-1:0]      r_hold_cnt, w_hold_nxt;
  logic [CNT_W-1:0]       r_loss_cnt, w_loss_nxt;
  logic [3:0]             r_rst, w_rst_nxt;
  logic                   r_ready, w_ready_nxt;
  logic                   r_pll_rst, w_pll_rst_nxt;
  logic                   w_lk;

  assign w_lk = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = '0;
    w_stab_nxt  = '0;
    w_rel_nxt   = '0;
    w_pll_nxt   = '0;
    w_hold_nxt  = '0;
    w_loss_nxt  = r_loss_cnt;
    unique case (r_state)
      S_WAIT_LOCK: begin
        if (soft_rst) begin
          w_state_nxt = S_LOST;
        end else if (w_lk) begin
          w_state_nxt = S_STABILIZE;
          w_stab_nxt  = STAB_W'(1);
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_state_nxt = S_PLL_RESET;
        end else begin
          w_tmo_nxt = r_tmo_cnt + 1'b1;
        end
      end
      S_PLL_RESET: begin
        if (r_pll_cnt == PLL_LAST) w_state_nxt = S_WAIT_LOCK;
        else                       w_pll_nxt   = r_pll_cnt + 1'b1;
      end
      S_STABILIZE: begin
        if (soft_rst)                      w_state_nxt = S_LOST;
        else if (!w_lk)                    w_state_nxt = S_WAIT_LOCK;
        else if (r_stab_cnt == STAB_DONE)  w_state_nxt = S_RELEASE;
        else                               w_stab_nxt  = r_stab_cnt + 1'b1;
      end
      S_RELEASE, S_RUN: begin
        // Only a genuine lock loss is counted, even when soft_rst coincides.
        if (soft_rst || !w_lk) begin
          w_state_nxt = S_LOST;
          if (!w_lk && (r_loss_cnt != '1)) w_loss_nxt = r_loss_cnt + 1'b1;
        end else if (r_state == S_RELEASE) begin
          if (r_rel_cnt == REL_LAST) w_state_nxt = S_RUN;
          else                       w_rel_nxt   = r_rel_cnt + 1'b1;
        end
      end
      S_LOST: begin
        if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_WAIT_LOCK;
        else                         w_hold_nxt  = r_hold_cnt + 1'b1;
      end
      default: w_state_nxt = S_WAIT_LOCK;
    endcase

    // Outputs are decoded from the next state so they land in the same cycle as the state.
    w_rst_nxt     = 4'b1111;
    w_ready_nxt   = 1'b0;
    w_pll_rst_nxt = (w_state_nxt == S_PLL_RESET);
    case (w_state_nxt)
      S_RELEASE: w_rst_nxt = {1'b0, (w_rel_nxt < REL_DDC), (w_rel_nxt < REL_FFT), 1'b1};
      S_RUN: begin
        w_rst_nxt   = 4'b0000;
        w_ready_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100m_in) begin
    if (rst) begin
      r_sync     <= '0;
      r_state    <= S_WAIT_LOCK;
      r_tmo_cnt  <= '0;
      r_stab_cnt <= '0;
      r_rel_cnt  <= '0;
      r_pll_cnt  <= '0;
      r_hold_cnt <= '0;
      r_loss_cnt <= '0;
      r_rst      <= 4'b1111;
      r_ready    <= 1'b0;
      r_pll_rst  <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], pll_locked};
      r_state    <= w_state_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
      r_stab_cnt <= w_stab_nxt;
      r_rel_cnt  <= w_rel_nxt;
      r_pll_cnt  <= w_pll_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_loss_cnt <= w_loss_nxt;
      r_rst      <= w_rst_nxt;
      r_ready    <= w_ready_nxt;
      r_pll_rst  <= w_pll_rst_nxt;
    end
  end

  assign {rst_adc, rst_ddc, rst_fft, rst_eth} = r_rst;
  assign sys_ready     = r_ready;
  assign pll_rst       = r_pll_rst;
  assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer
module tb_reset_sequencer;
  localparam int SYNC = 2, LSC = 8, GAP = 4, TMO = 32, PRC = 3, HOLD = 5, CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int P_WAIT = 0, P_PLL = 1, P_STAB = 2, P_REL = 3, P_RUN = 4, P_LOST = 5;

  logic          clk = 1'b0;
  logic          tb_rst, tb_pll, tb_soft;
  logic          pll_rst, rst_adc, rst_ddc, rst_fft, rst_eth, sys_ready;
  logic [CW-1:0] lock_loss_cnt;

  int checks = 0, failures = 0, cyc = 0;

  reset_sequencer #(
    .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(LSC), .STAGE_GAP(GAP), .LOCK_TIMEOUT(TMO),
    .PLL_RST_CYCLES(PRC), .HOLD_CYCLES(HOLD), .CNT_W(CW)
  ) dut (
    .clk_100m_in(clk), .rst(tb_rst), .pll_locked(tb_pll), .soft_rst(tb_soft),
    .pll_rst(pll_rst), .rst_adc(rst_adc), .rst_ddc(rst_ddc), .rst_fft(rst_fft),
    .rst_eth(rst_eth), .sys_ready(sys_ready), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  // Reference: phase plus time-in-phase; lk is pll_locked delayed through a queue.
  int m_phase, m_t, m_cnt;
  bit m_lk;
  bit m_q[$];

  task automatic model_reset();
    m_phase = P_WAIT; m_t = 0; m_cnt = 0; m_lk = 1'b0;
    m_q.delete();
    repeat (SYNC) m_q.push_back(1'b0);
  endtask

  task automatic model_step(input bit r, input bit p, input bit s);
    int nxt;
    if (r) begin
      model_reset();
      return;
    end
    nxt = m_phase;
    case (m_phase)
      P_WAIT: if (s) nxt = P_LOST; else if (m_lk) nxt = P_STAB; else if (m_t == TMO - 1) nxt = P_PLL;
      P_PLL:  if (m_t == PRC - 1) nxt = P_WAIT;
      P_STAB: if (s) nxt = P_LOST; else if (!m_lk) nxt = P_WAIT; else if (m_t == LSC - 1) nxt = P_REL;
      P_REL, P_RUN: begin
        if (!m_lk || s) begin
          nxt = P_LOST;
          if (!m_lk && m_cnt < CNT_MAX) m_cnt++;
        end else if (m_phase == P_REL && m_t == 3 * GAP - 1) nxt = P_RUN;
      end
      P_LOST: if (m_t == HOLD - 1) nxt = P_WAIT;
      default: nxt = P_WAIT;
    endcase
    m_t = (nxt == m_phase) ? m_t + 1 : 0;
    m_phase = nxt;
    m_q.push_back(p);
    void'(m_q.pop_front());
    m_lk = m_q[0];
  endtask

  function automatic logic [13:0] model_vec();
    int n;
    n = (m_phase == P_REL) ? 1 + m_t / GAP : (m_phase == P_RUN) ? 4 : 0;
    return {n < 1, n < 2, n < 3, n < 4, m_phase == P_RUN, m_phase == P_PLL, 8'(m_cnt)};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {rst_adc, rst_ddc, rst_fft, rst_eth, sys_ready, pll_rst, lock_loss_cnt};
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(tb_rst, tb_pll, tb_soft);
    #1;
    cyc++;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic wait_for(input string name, input bit use_ready, input bit val, input int budget);
    int k = 0;
    while (((use_ready ? sys_ready : rst_adc) !== val) && k < budget) begin
      tick();
      k++;
    end
    chk(name, {13'd0, use_ready ? sys_ready : rst_adc}, {13'd0, val});
  endtask

  typedef struct {
    int          n;
    bit          r, p, s;
    logic [13:0] exp;
  } vec_t;

  function automatic vec_t mk(input int n, input bit r, input bit p, input bit s,
                              input logic [3:0] rs, input bit rdy, input bit pr, input int c);
    vec_t v;
    v.n = n; v.r = r; v.p = p; v.s = s;
    v.exp = {rs, rdy, pr, 8'(c)};
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    int first_rise, second_rise, pulses, bad_dom;
    bit prev;

    tb_rst = 1'b1; tb_pll = 1'b0; tb_soft = 1'b0;

    // Clean bring-up, lock loss in RUN and lk ignored during the hold (cycle counts in comments)
    tbl[0]  = mk(3,  1, 0, 0, 4'b1111, 0, 0, 0);  // 3
    tbl[1]  = mk(7,  0, 0, 0, 4'b1111, 0, 0, 0);  // 10
    tbl[2]  = mk(10, 0, 1, 0, 4'b1111, 0, 0, 0);  // 20
    tbl[3]  = mk(1,  0, 1, 0, 4'b0111, 0, 0, 0);  // 21
    tbl[4]  = mk(3,  0, 1, 0, 4'b0111, 0, 0, 0);  // 24
    tbl[5]  = mk(1,  0, 1, 0, 4'b0011, 0, 0, 0);  // 25
    tbl[6]  = mk(3,  0, 1, 0, 4'b0011, 0, 0, 0);  // 28
    tbl[7]  = mk(1,  0, 1, 0, 4'b0001, 0, 0, 0);  // 29
    tbl[8]  = mk(3,  0, 1, 0, 4'b0001, 0, 0, 0);  // 32
    tbl[9]  = mk(1,  0, 1, 0, 4'b0000, 1, 0, 0);  // 33
    tbl[10] = mk(5,  0, 1, 0, 4'b0000, 1, 0, 0);  // 38
    tbl[11] = mk(2,  0, 0, 0, 4'b0000, 1, 0, 0);  // 40
    tbl[12] = mk(1,  0, 0, 0, 4'b1111, 0, 0, 1);  // 41
    tbl[13] = mk(4,  0, 1, 0, 4'b1111, 0, 0, 1);  // 45
    tbl[14] = mk(9,  0, 1, 0, 4'b1111, 0, 0, 1);  // 54
    tbl[15] = mk(1,  0, 1, 0, 4'b0111, 0, 0, 1);  // 55

    for (int i = 0; i < 16; i++) begin
      tb_rst = tbl[i].r; tb_pll = tbl[i].p; tb_soft = tbl[i].s;
      repeat (tbl[i].n) tick();
      chk($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
    end

    // Lock glitch during stabilisation
    tb_rst = 1'b1; tb_pll = 1'b0; repeat (2) tick();
    tb_rst = 1'b0; tb_pll = 1'b1; repeat (5) tick();
    tb_pll = 1'b0; tick();
    tb_pll = 1'b1; repeat (10) tick();
    chk("glitch_hold", {13'd0, rst_adc}, 14'd1);
    tick();
    chk("glitch_release", {13'd0, rst_adc}, 14'd0);
    chk("glitch_cnt", {6'd0, lock_loss_cnt}, 14'd0);

    // Lock timeout and repeated PLL reset pulses
    tb_rst = 1'b1; tb_pll = 1'b0; tick();
    tb_rst = 1'b0;
    first_rise = -1; second_rise = -1; pulses = 0; bad_dom = 0; prev = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (pll_rst) begin
        pulses++;
        if (!prev) begin
          if (first_rise < 0) first_rise = c;
          else if (second_rise < 0) second_rise = c;
        end
      end
      if ({rst_adc, rst_ddc, rst_fft, rst_eth} !== 4'b1111) bad_dom++;
      prev = pll_rst;
    end
    chk("tmo_first_rise", 14'(first_rise), 14'd32);
    chk("tmo_second_rise", 14'(second_rise), 14'd67);
    chk("tmo_pulse_cycles", 14'(pulses), 14'd6);
    chk("tmo_domains_held", 14'(bad_dom), 14'd0);

    // Soft reset in RUN, then soft reset coincident with lock loss
    tb_rst = 1'b1; tick();
    tb_rst = 1'b0; tb_pll = 1'b1;
    wait_for("soft_reach_run", 1'b1, 1'b1, 60);
    tb_soft = 1'b1; tick(); tb_soft = 1'b0;
    chk("soft_assert", dut_vec(), {4'b1111, 1'b0, 1'b0, 8'd0});
    repeat (13) tick();
    chk("soft_rerelease_hold", {13'd0, rst_adc}, 14'd1);
    tick();
    chk("soft_rerelease", {13'd0, rst_adc}, 14'd0);
    wait_for("soft_reach_run2", 1'b1, 1'b1, 40);
    tb_pll = 1'b0; repeat (2) tick();
    tb_soft = 1'b1; tick(); tb_soft = 1'b0;
    chk("soft_and_loss", dut_vec(), {4'b1111, 1'b0, 1'b0, 8'd1});

    // Counter saturation after 260 further lock losses
    for (int i = 0; i < 260; i++) begin
      tb_pll = 1'b1;
      wait_for("sat_release", 1'b0, 1'b0, 40);
      tb_pll = 1'b0;
      wait_for("sat_loss", 1'b0, 1'b1, 10);
    end
    chk("saturate", {6'd0, lock_loss_cnt}, 14'(CNT_MAX));

    // rst asserted mid-RELEASE
    tb_pll = 1'b1;
    wait_for("midop_release", 1'b0, 1'b0, 40);
    repeat (2) tick();
    tb_rst = 1'b1; tick();
    chk("midop_rst", dut_vec(), {4'b1111, 1'b0, 1'b0, 8'd0});
    tb_rst = 1'b0;

    // Randomised traffic against the reference model
    for (int i = 0; i < 4000; i++) begin
      if (tb_pll) begin
        if ($urandom_range(59) == 0) tb_pll = 1'b0;
      end else if ($urandom_range(24) == 0) begin
        tb_pll = 1'b1;
      end
      tb_soft = ($urandom_range(149) == 0);
      tb_rst  = ($urandom_range(999) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
